// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave with NUM_REGS 32-bit byte-writable registers and independent read/write FSMs.
// Register 0 is also driven out on REG0 for direct display.
module axil_slave_regfile #(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic [31:0]       REG0
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  logic [31:0]       regs_r [NUM_REGS];
  logic              init_done_r;
  w_state_t          w_state_r, w_state_s;
  r_state_t          r_state_r, r_state_s;
  logic [ADDR_W-1:0] aw_addr_r;
  logic [31:0]       w_data_r;
  logic [3:0]        w_strb_r;
  logic [1:0]        bresp_r;
  logic [31:0]       rdata_r;
  logic [1:0]        rresp_r;

  logic              awready_s, wready_s, arready_s, bvalid_s, rvalid_s;
  logic              aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic              commit_s;
  logic [ADDR_W-1:0] cm_addr_s;
  logic [31:0]       cm_data_s;
  logic [3:0]        cm_strb_s;
  logic              unused_s;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (a >> (IDX_W + 2)) == {ADDR_W{1'b0}};
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign aw_hs_s = AWVALID & awready_s;
  assign w_hs_s  = WVALID & wready_s;
  assign ar_hs_s = ARVALID & arready_s;
  assign b_hs_s  = bvalid_s & BREADY;
  assign r_hs_s  = rvalid_s & RREADY;

  // Half of the write pair may already be latched; the other half comes straight off the bus.
  assign cm_addr_s = (w_state_r == W_HAVE_A) ? aw_addr_r : AWADDR;
  assign cm_data_s = (w_state_r == W_HAVE_D) ? w_data_r : WDATA;
  assign cm_strb_s = (w_state_r == W_HAVE_D) ? w_strb_r : WSTRB;

  // State registers; init_done_r holds the READYs low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_r   <= W_IDLE;
      r_state_r   <= R_IDLE;
      init_done_r <= 1'b0;
    end else begin
      w_state_r   <= w_state_s;
      r_state_r   <= r_state_s;
      init_done_r <= 1'b1;
    end
  end

  // Write FSM next state; commit_s marks the edge that enters W_RESP.
  always_comb begin
    w_state_s = w_state_r;
    commit_s  = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_state_s = W_RESP;
          commit_s  = 1'b1;
        end else if (aw_hs_s) begin
          w_state_s = W_HAVE_A;
        end else if (w_hs_s) begin
          w_state_s = W_HAVE_D;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_HAVE_A: begin
        if (w_hs_s) begin
          w_state_s = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_s = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        if (aw_hs_s) begin
          w_state_s = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_s = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (b_hs_s) w_state_s = W_IDLE;
        else        w_state_s = W_RESP;
      end
      default: w_state_s = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) r_state_s = R_DATA;
        else         r_state_s = R_IDLE;
      end
      R_DATA: begin
        if (r_hs_s) r_state_s = R_IDLE;
        else        r_state_s = R_DATA;
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Channel handshake outputs decoded from the registered states.
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (w_state_r)
      W_IDLE:   begin awready_s = init_done_r; wready_s = init_done_r; end
      W_HAVE_A: wready_s  = 1'b1;
      W_HAVE_D: awready_s = 1'b1;
      W_RESP:   bvalid_s  = 1'b1;
      default:  bvalid_s  = 1'b0;
    endcase
    case (r_state_r)
      R_IDLE:  arready_s = init_done_r;
      R_DATA:  rvalid_s  = 1'b1;
      default: rvalid_s  = 1'b0;
    endcase
  end

  // Register bank, write-side latches and response capture; a same-edge read sees the pre-commit value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0000_0000;
      aw_addr_r <= {ADDR_W{1'b0}};
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'b0000;
      bresp_r   <= RESP_OKAY;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= RESP_OKAY;
    end else begin
      if (aw_hs_s) aw_addr_r <= AWADDR;
      if (w_hs_s) begin
        w_data_r <= WDATA;
        w_strb_r <= WSTRB;
      end
      if (commit_s) begin
        if (addr_in_range(cm_addr_s)) begin
          regs_r[addr_index(cm_addr_s)] <=
            merge_bytes(regs_r[addr_index(cm_addr_s)], cm_data_s, cm_strb_s);
          bresp_r <= RESP_OKAY;
        end else begin
          bresp_r <= RESP_SLVERR;
        end
      end
      if (ar_hs_s) begin
        if (addr_in_range(ARADDR)) begin
          rdata_r <= regs_r[addr_index(ARADDR)];
          rresp_r <= RESP_OKAY;
        end else begin
          rdata_r <= 32'h0000_0000;
          rresp_r <= RESP_SLVERR;
        end
      end
    end
  end

  assign AWREADY = awready_s;
  assign WREADY  = wready_s;
  assign BVALID  = bvalid_s;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_s;
  assign RVALID  = rvalid_s;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;
  assign REG0    = regs_r[0];

  // Protection bits and byte-lane address bits carry no meaning for this slave.
  assign unused_s = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], aw_addr_r[1:0]};

endmodule
